// File: rtl/hazard_ctrl.sv
// Hazard/sequencing control: stall F/D + bubble D/E, flush on int_req, HI/LO busy counter.
// stall/flush combinational; md_busy/md_done registered (start in t -> busy t+1..t+N).
// Backpressure: stall holds F/D while hazards persist; HAZARD_STALL_CNT_EN adds a stall counter.
module hazard_ctrl #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  D_rs,
   input  logic [4:0]  D_rt,
   input  logic [1:0]  D_Tuse_rs,
   input  logic [1:0]  D_Tuse_rt,
   input  logic [4:0]  E_A3,
   input  logic [4:0]  M_A3,
   input  logic [1:0]  E_Tnew,
   input  logic [1:0]  M_Tnew,
   input  logic        D_md,
   input  logic [1:0]  E_md_op,
   input  logic        D_eret,
   input  logic        E_mtc0_epc,
   input  logic        M_mtc0_epc,
   input  logic        int_req,
   output logic        stall,
   output logic        flush,
   output logic        md_busy,
   output logic        md_done,
   output logic [31:0] stall_cnt
);

   typedef enum logic {IDLE, BUSY} md_state_t;

   localparam logic [3:0] MULT_N = 4'(MULT_CYC);
   localparam logic [3:0] DIV_N  = 4'(DIV_CYC);

   md_state_t  state;
   logic [3:0] cnt;
   logic [3:0] cnt_nxt;
   logic       md_start;
   logic       rs_haz;
   logic       rt_haz;
   logic       md_haz;
   logic       eret_haz;

   // Equal Tnew/Tuse is covered by forwarding, so only a strictly later result stalls.
   function automatic logic reg_haz(input logic [4:0] src, input logic [1:0] tuse,
                                    input logic [4:0] e_dst, input logic [1:0] e_tnew,
                                    input logic [4:0] m_dst, input logic [1:0] m_tnew);
      logic e_hit;
      logic m_hit;
      e_hit = (e_dst == src) && (e_tnew > tuse);
      m_hit = (m_dst == src) && (m_tnew > tuse);
      return (src != 5'd0) && (e_hit || m_hit);
   endfunction

   always_comb begin
      rs_haz   = reg_haz(D_rs, D_Tuse_rs, E_A3, E_Tnew, M_A3, M_Tnew);
      rt_haz   = reg_haz(D_rt, D_Tuse_rt, E_A3, E_Tnew, M_A3, M_Tnew);
      md_start = ((E_md_op == 2'b01) || (E_md_op == 2'b10)) && !md_busy && !int_req;
      md_haz   = D_md && (md_start || md_busy);
      eret_haz = D_eret && (E_mtc0_epc || M_mtc0_epc);
      stall    = !int_req && (rs_haz || rt_haz || md_haz || eret_haz);
      flush    = int_req;
   end

   // A new op is only accepted from idle; a request while busy is dropped, not reloaded.
   always_comb begin
      cnt_nxt = cnt;
      if (md_start) begin
         cnt_nxt = (E_md_op == 2'b01) ? MULT_N : DIV_N;
      end else if (cnt != 4'd0) begin
         cnt_nxt = cnt - 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         md_busy <= 1'b0;
         md_done <= 1'b0;
      end else begin
         case (state)
            IDLE: if (md_start) state <= BUSY;
            BUSY: if (cnt_nxt == 4'd0) state <= IDLE;
            default: state <= IDLE;
         endcase
         cnt     <= cnt_nxt;
         md_busy <= (cnt_nxt != 4'd0);
         md_done <= (cnt_nxt == 4'd1);
      end
   end

`ifdef HAZARD_STALL_CNT_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= 32'd0;
      end else if (stall) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage MIPS core. It decides each cycle whether the F/D stage freezes and a bubble enters D/E. It also sequences the multi-cycle HI/LO multiply/divide unit with a busy counter, and gates ERET behind in-flight EPC writes. It drives the stall and flush inputs of the F/D, D/E, E/M and M/W pipeline registers.

## Interface
Parameters:
- MULT_CYC, 5, busy cycles for mult/multu (legal 1..15)
- DIV_CYC, 10, busy cycles for div/divu (legal 1..15)

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- D_rs, D_rt  in  5  source register numbers of the D-stage instruction
- D_Tuse_rs, D_Tuse_rt  in  2  cycles until D needs rs/rt (3 = unused)
- E_A3, M_A3  in  5  destination register of the E and M stages (0 = none)
- E_Tnew, M_Tnew  in  2  cycles until the E and M results are forwardable
- D_md  in  1  D instruction touches HI/LO (mult/div/mfhi/mflo/mthi/mtlo)
- E_md_op  in  2  00 none, 01 mult/multu, 10 div/divu, 11 reserved (treated as none)
- D_eret  in  1  D instruction is eret
- E_mtc0_epc, M_mtc0_epc  in  1  E or M holds an mtc0 targeting EPC
- int_req  in  1  exception or interrupt taken at M this cycle
- stall  out  1  freeze PC and F/D, insert a bubble into D/E
- flush  out  1  clear F/D, D/E, E/M; equals int_req
- md_busy  out  1  multiply/divide unit occupied
- md_done  out  1  one-cycle pulse on the last busy cycle (HI/LO write enable)
- stall_cnt  out  32  stall-cycle counter (only with macro, else 0)

## Operation
- Register hazard on rs: stall when D_rs != 0 and either (E_A3 == D_rs and E_Tnew > D_Tuse_rs) or (M_A3 == D_rs and M_Tnew > D_Tuse_rs). rt is checked the same way. Equal Tnew and Tuse means forwarding covers it, so no stall.
- MD start: md_start = (E_md_op is 01 or 10) and !md_busy and !int_req.
- MD counter: 4-bit cnt. Loads MULT_CYC or DIV_CYC on md_start, decrements while nonzero.
- md_busy = (cnt != 0). md_done = (cnt == 1).
- FSM states: IDLE (cnt = 0) goes to BUSY on md_start. BUSY goes to IDLE when cnt reaches 0.
- MD hazard: stall when D_md and (md_start or md_busy).
- An E_md_op asserted while md_busy is ignored, with no reload.
- ERET hazard: stall when D_eret and (E_mtc0_epc or M_mtc0_epc).
- stall is the OR of the rs, rt, MD and ERET hazards, forced to 0 when int_req = 1. flush has priority.
- int_req during BUSY does not abort the counter: the operation was issued before the faulting instruction.
- int_req in the same cycle as an E mult/div suppresses md_start. That instruction is flushed.

## Timing
- Reset values: cnt = 0, md_busy = 0, md_done = 0, stall_cnt = 0. stall and flush follow their inputs combinationally.
- stall and flush are combinational, same cycle as their inputs.
- If md_start is asserted in cycle t, md_busy = 1 in cycles t+1 .. t+N and md_done = 1 in cycle t+N only.
- The MD stall covers cycles t .. t+N. A D-stage mfhi is released in cycle t+N+1.
- Back-to-back MD: a second start is possible at the earliest in cycle t+N+1.
- rst asserted mid-operation clears cnt immediately (asynchronous), so md_busy and md_done drop without waiting for a clock edge.

## Configuration
- Macro HAZARD_STALL_CNT_EN.
- Defined: stall_cnt increments on every rising edge where stall = 1 and rst = 0. It wraps from 0xFFFFFFFF to 0.
- Undefined: no counter register is built and stall_cnt is tied to 0.

## Test plan
- Load-use: E_A3 = 8, E_Tnew = 2, D_rs = 8, D_Tuse_rs = 1 -> stall = 1. With E_Tnew = 1 -> stall = 0. With D_rs = 0 and E_A3 = 0 -> stall = 0.
- Mult sequencing: E_md_op = 01 at cycle 0, D_md = 1 held -> stall = 1 in cycles 0..5, md_busy = 1 in cycles 1..5, md_done = 1 in cycle 5 only, stall = 0 in cycle 6.
- Div with a retrigger: E_md_op = 10 at cycle 0, again at cycle 3 -> no reload, md_done = 1 at cycle 10 only.
- Interrupt collision: int_req = 1 and E_md_op = 01 in the same cycle -> flush = 1, stall = 0, md_busy stays 0.
- ERET gate: D_eret = 1 with M_mtc0_epc = 1 -> stall = 1. Next cycle with both mtc0 flags at 0 -> stall = 0.
- Reset mid-div at cycle 4 -> md_busy = 0 immediately. With the macro defined, a 7-cycle stall run gives stall_cnt = 7, and 0 after reset.
